s_trap_sequencer: RTL and testbench
===================================

Name: s_trap_sequencer

Overview:
- Trap-entry / SRET sequencer for supervisor mode; it drives the write/read port of the supervisor CSR file.
- The CSR file raises exceptions. This block takes a trap request (or an SRET) from the pipeline and performs the side of the protocol that stores state into the CSR file:
  - on trap: writes sepc, scause and stval, and read-modify-writes sstatus;
  - on either: reads the target address, then issues a single PC/privilege redirect to fetch.
- Multi-cycle FSM, one CSR access per cycle; holds the pipeline while busy.

Parameters:
XLEN, 64, datapath width; only 64 supported
ILL_CAUSE, 4'd2, scause code used for SRET attempted from U-mode

Ports:
clk  input  1  clock
rst  input  1  synchronous active-high reset
trap_req  input  1  pipeline exception request, sampled in IDLE only
trap_cause  input  4  exception code
trap_val  input  64  value for stval
trap_pc  input  64  PC of faulting instruction
sret_req  input  1  SRET retiring, sampled in IDLE only
priv_lvl  input  2  current privilege (0=U, 1=S)
csr_rdata  input  64  CSR file read data (combinational on csr_addr)
csr_we  output  1  CSR write enable
csr_addr  output  12  CSR address
csr_wdata  output  64  CSR write data
csr_priv  output  2  privilege presented to CSR file while busy: 2'b01
busy  output  1  high in every non-IDLE state; pipeline stalls
redirect_valid  output  1  one-cycle pulse: redirect_pc/new_priv valid
redirect_pc  output  64  next fetch PC
new_priv  output  2  privilege after redirect

Behaviour:
- Reset: state=IDLE; all outputs 0; internal latches (pc, cause, val, sstatus copy, target) 0.
- Reset asserted mid-sequence: next cycle IDLE, csr_we=0; no further CSR writes; no redirect.
- In IDLE: csr_we=0, csr_addr=0, csr_priv=0.
- In IDLE on a clock edge:
  - trap_req=1: latch trap_pc, cause, val and priv_lvl; go to T_SEPC.
  - else sret_req=1 with priv_lvl=U: latch trap_pc, cause=ILL_CAUSE, val=0; go to T_SEPC (illegal SRET).
  - else sret_req=1: latch priv_lvl; go to R_SST_RD.
  - trap_req and sret_req together: trap wins, SRET is dropped.
- Requests in any non-IDLE state are ignored; the pipeline must hold them, which busy guarantees.
- Trap path, one state per cycle:
  - T_SEPC: we=1, addr 0x141, wdata = {pc[63:1],1'b0}.
  - T_SCAUSE: we=1, addr 0x142, wdata = {60'b0, cause}; interrupt bit is always 0.
  - T_STVAL: we=1, addr 0x143, wdata = val.
  - T_SST_RD: we=0, addr 0x100; latch csr_rdata as ss.
  - T_SST_WR: we=1, addr 0x100, wdata = ss with bit5 (SPIE)=ss[1], bit1 (SIE)=0, bit8 (SPP)=(latched priv==S); other bits unchanged.
  - T_VEC_RD: we=0, addr 0x105; target = {rdata[63:2],2'b00}. Mode bits are ignored because only exceptions exist, so there is no vectoring.
  - DONE: redirect_valid=1, redirect_pc=target, new_priv=2'b01; next state IDLE.
- SRET path:
  - R_SST_RD: we=0, addr 0x100; latch ss.
  - R_SST_WR: we=1, addr 0x100, wdata = ss with SIE=ss[5], SPIE=1, SPP=0.
  - R_EPC_RD: we=0, addr 0x141; target = {rdata[63:1],1'b0}; new_priv = ss[8] ? 2'b01 : 2'b00.
  - DONE: as for trap, but new_priv as computed.
- Latency, with the request seen at edge 0:
  - trap: redirect_valid high in cycle 7 after that edge;
  - SRET: redirect_valid high in cycle 4.
  - busy spans exactly 7 / 4 cycles. redirect_pc and new_priv hold their values until the next DONE.
- csr_priv = 2'b01 in all non-IDLE states, so CSR file privilege checks pass when a trap is taken from U.
- csr_wdata = 0 whenever csr_we=0.
- Back-to-back: a request present in the cycle after DONE (state now IDLE) is accepted normally. There is no dead cycle beyond IDLE itself.

Test Plan:
- Trap from U: pc=0x8000_0103, cause=2, val=0x142, stvec=0x8000_1001, sstatus=0x2 -> writes sepc=0x8000_0102, scause=2, stval=0x142, sstatus=0x20; redirect_valid in cycle 7 with pc=0x8000_1000, new_priv=1; busy high 7 cycles.
- SRET from S: sstatus=0x120, sepc=0x4001 -> sstatus written 0x22; redirect pc=0x4000, new_priv=1, in cycle 4.
- SRET with SPP=0: sstatus=0x020 -> new_priv=0; sstatus written 0x22.
- Illegal SRET from U -> full trap sequence with scause=2, stval=0, SPP=0.
- trap_req and sret_req asserted together -> trap path taken; a new trap_req pulsed during busy is ignored (exactly one redirect).
- rst asserted in T_SST_RD -> next cycle busy=0, csr_we=0, redirect_valid never pulses; a following trap completes normally.

Source files
------------

// File: rtl/s_trap_sequencer.sv
// Supervisor trap-entry / SRET sequencer driving the S-mode CSR file one access per cycle.
// Trap: redirect 7 cycles after acceptance; SRET: 4 cycles. busy stalls the pipeline, so requests seen outside IDLE are dropped.
module s_trap_sequencer #(
  parameter int unsigned XLEN      = 64,
  parameter logic [3:0]  ILL_CAUSE = 4'd2
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            trap_req,
  input  logic [3:0]      trap_cause,
  input  logic [XLEN-1:0] trap_val,
  input  logic [XLEN-1:0] trap_pc,
  input  logic            sret_req,
  input  logic [1:0]      priv_lvl,
  input  logic [XLEN-1:0] csr_rdata,
  output logic            csr_we,
  output logic [11:0]     csr_addr,
  output logic [XLEN-1:0] csr_wdata,
  output logic [1:0]      csr_priv,
  output logic            busy,
  output logic            redirect_valid,
  output logic [XLEN-1:0] redirect_pc,
  output logic [1:0]      new_priv
);

  localparam logic [11:0] A_SSTATUS = 12'h100;
  localparam logic [11:0] A_STVEC   = 12'h105;
  localparam logic [11:0] A_SEPC    = 12'h141;
  localparam logic [11:0] A_SCAUSE  = 12'h142;
  localparam logic [11:0] A_STVAL   = 12'h143;
  localparam logic [1:0]  PRIV_U    = 2'b00;
  localparam logic [1:0]  PRIV_S    = 2'b01;

  typedef enum logic [3:0] {
    IDLE, T_SEPC, T_SCAUSE, T_STVAL, T_SST_RD, T_SST_WR, T_VEC_RD,
    DONE, R_SST_RD, R_SST_WR, R_EPC_RD
  } state_e;

  state_e          state_q, state_d;
  logic [XLEN-1:0] pc_q, pc_d;
  logic [3:0]      cause_q, cause_d;
  logic [XLEN-1:0] val_q, val_d;
  logic [1:0]      priv_q, priv_d;
  logic [XLEN-1:0] ss_q, ss_d;
  logic [XLEN-1:0] tgt_q, tgt_d;
  logic [1:0]      tpriv_q, tpriv_d;
  logic [XLEN-1:0] rpc_q, rpc_d;
  logic [1:0]      rpriv_q, rpriv_d;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      pc_q    <= '0;
      cause_q <= '0;
      val_q   <= '0;
      priv_q  <= '0;
      ss_q    <= '0;
      tgt_q   <= '0;
      tpriv_q <= '0;
      rpc_q   <= '0;
      rpriv_q <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      cause_q <= cause_d;
      val_q   <= val_d;
      priv_q  <= priv_d;
      ss_q    <= ss_d;
      tgt_q   <= tgt_d;
      tpriv_q <= tpriv_d;
      rpc_q   <= rpc_d;
      rpriv_q <= rpriv_d;
    end
  end

  always_comb begin
    state_d        = state_q;
    pc_d           = pc_q;
    cause_d        = cause_q;
    val_d          = val_q;
    priv_d         = priv_q;
    ss_d           = ss_q;
    tgt_d          = tgt_q;
    tpriv_d        = tpriv_q;
    rpc_d          = rpc_q;
    rpriv_d        = rpriv_q;
    csr_we         = 1'b0;
    csr_addr       = '0;
    csr_wdata      = '0;
    csr_priv       = PRIV_S;
    busy           = 1'b1;
    redirect_valid = 1'b0;
    redirect_pc    = rpc_q;
    new_priv       = rpriv_q;

    case (state_q)
      IDLE: begin
        csr_priv = PRIV_U;
        busy     = 1'b0;
        if (trap_req) begin
          pc_d    = trap_pc;
          cause_d = trap_cause;
          val_d   = trap_val;
          priv_d  = priv_lvl;
          state_d = T_SEPC;
        end else if (sret_req && priv_lvl == PRIV_U) begin
          // SRET from U-mode becomes an illegal-instruction trap
          pc_d    = trap_pc;
          cause_d = ILL_CAUSE;
          val_d   = '0;
          priv_d  = priv_lvl;
          state_d = T_SEPC;
        end else if (sret_req) begin
          priv_d  = priv_lvl;
          state_d = R_SST_RD;
        end
      end
      T_SEPC: begin
        csr_we    = 1'b1;
        csr_addr  = A_SEPC;
        csr_wdata = {pc_q[XLEN-1:1], 1'b0};
        state_d   = T_SCAUSE;
      end
      T_SCAUSE: begin
        csr_we    = 1'b1;
        csr_addr  = A_SCAUSE;
        csr_wdata = {{(XLEN-4){1'b0}}, cause_q};
        state_d   = T_STVAL;
      end
      T_STVAL: begin
        csr_we    = 1'b1;
        csr_addr  = A_STVAL;
        csr_wdata = val_q;
        state_d   = T_SST_RD;
      end
      T_SST_RD: begin
        csr_addr = A_SSTATUS;
        ss_d     = csr_rdata;
        state_d  = T_SST_WR;
      end
      T_SST_WR: begin
        csr_we       = 1'b1;
        csr_addr     = A_SSTATUS;
        csr_wdata    = ss_q;
        csr_wdata[5] = ss_q[1];
        csr_wdata[1] = 1'b0;
        csr_wdata[8] = (priv_q == PRIV_S);
        state_d      = T_VEC_RD;
      end
      T_VEC_RD: begin
        // Only exceptions are taken, so stvec mode bits never select vectoring
        csr_addr = A_STVEC;
        tgt_d    = {csr_rdata[XLEN-1:2], 2'b00};
        tpriv_d  = PRIV_S;
        state_d  = DONE;
      end
      DONE: begin
        redirect_valid = 1'b1;
        redirect_pc    = tgt_q;
        new_priv       = tpriv_q;
        rpc_d          = tgt_q;
        rpriv_d        = tpriv_q;
        state_d        = IDLE;
      end
      R_SST_RD: begin
        csr_addr = A_SSTATUS;
        ss_d     = csr_rdata;
        state_d  = R_SST_WR;
      end
      R_SST_WR: begin
        csr_we       = 1'b1;
        csr_addr     = A_SSTATUS;
        csr_wdata    = ss_q;
        csr_wdata[1] = ss_q[5];
        csr_wdata[5] = 1'b1;
        csr_wdata[8] = 1'b0;
        state_d      = R_EPC_RD;
      end
      R_EPC_RD: begin
        csr_addr = A_SEPC;
        tgt_d    = {csr_rdata[XLEN-1:1], 1'b0};
        tpriv_d  = ss_q[8] ? PRIV_S : PRIV_U;
        state_d  = DONE;
      end
      default: state_d = IDLE;
    endcase
  end

endmodule

// File: tb/tb_s_trap_sequencer.sv
// Table-driven bench for s_trap_sequencer with a behavioural CSR file and a write scoreboard.
module tb_s_trap_sequencer;

  logic        clk = 1'b0;
  logic        rst;
  logic        trap_req, sret_req;
  logic [3:0]  trap_cause;
  logic [63:0] trap_val, trap_pc, csr_rdata, csr_wdata, redirect_pc;
  logic [1:0]  priv_lvl, csr_priv, new_priv;
  logic        csr_we, busy, redirect_valid;
  logic [11:0] csr_addr;

  always #5 clk = ~clk;

  s_trap_sequencer #(.XLEN(64), .ILL_CAUSE(4'd2)) dut (
    .clk(clk), .rst(rst), .trap_req(trap_req), .trap_cause(trap_cause),
    .trap_val(trap_val), .trap_pc(trap_pc), .sret_req(sret_req), .priv_lvl(priv_lvl),
    .csr_rdata(csr_rdata), .csr_we(csr_we), .csr_addr(csr_addr), .csr_wdata(csr_wdata),
    .csr_priv(csr_priv), .busy(busy), .redirect_valid(redirect_valid),
    .redirect_pc(redirect_pc), .new_priv(new_priv)
  );

  logic [63:0] m_sstatus, m_stvec, m_sepc, m_scause, m_stval;

  always_comb begin
    csr_rdata = '0;
    case (csr_addr)
      12'h100: csr_rdata = m_sstatus;
      12'h105: csr_rdata = m_stvec;
      12'h141: csr_rdata = m_sepc;
      12'h142: csr_rdata = m_scause;
      12'h143: csr_rdata = m_stval;
      default: csr_rdata = '0;
    endcase
  end

  typedef struct {
    bit          trap;
    bit          sret;
    logic [1:0]  priv;
    logic [63:0] pc;
    logic [3:0]  cause;
    logic [63:0] val;
    logic [63:0] sst0;
    logic [63:0] stvec;
    logic [63:0] sepc0;
    logic [63:0] e_sepc;
    logic [63:0] e_cause;
    logic [63:0] e_stval;
    logic [63:0] e_sst;
    logic [63:0] e_pc;
    logic [1:0]  e_np;
    int          lat;
    int          rst_cyc;
    int          tail;
    bit          pulse;
  } vec_t;

  typedef struct {
    int          cyc;
    logic [11:0] addr;
    logic [63:0] data;
  } wexp_t;

  vec_t  vt[10];
  wexp_t wq[$];
  int    n_vec = 0;
  int    n_bad = 0;
  logic [63:0] prev_pc;
  logic [1:0]  prev_np;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h required %h", nm, act, exp);
    end
  endtask

  task automatic model_wr(input logic [11:0] a, input logic [63:0] d);
    case (a)
      12'h100: m_sstatus = d;
      12'h105: m_stvec   = d;
      12'h141: m_sepc    = d;
      12'h142: m_scause  = d;
      12'h143: m_stval   = d;
      default: ;
    endcase
  endtask

  task automatic push_w(input int cyc, input logic [11:0] a, input logic [63:0] d, input int rc);
    wexp_t w;
    if (rc == 0 || cyc <= rc) begin
      w.cyc = cyc; w.addr = a; w.data = d;
      wq.push_back(w);
    end
  endtask

  task automatic run_seq(input int idx, input vec_t v);
    int    last;
    wexp_t w;
    string tag;
    m_sstatus = v.sst0; m_stvec = v.stvec; m_sepc = v.sepc0;
    trap_req = v.trap; sret_req = v.sret; priv_lvl = v.priv;
    trap_pc = v.pc; trap_cause = v.cause; trap_val = v.val;
    if (v.lat == 7) begin
      push_w(1, 12'h141, v.e_sepc, v.rst_cyc);
      push_w(2, 12'h142, v.e_cause, v.rst_cyc);
      push_w(3, 12'h143, v.e_stval, v.rst_cyc);
      push_w(5, 12'h100, v.e_sst, v.rst_cyc);
    end else begin
      push_w(2, 12'h100, v.e_sst, v.rst_cyc);
    end
    @(posedge clk); #1;
    // Scramble request inputs to prove they were captured at acceptance
    trap_req = 1'b0; sret_req = 1'b0; priv_lvl = 2'b10;
    trap_pc = 64'hA5A5_A5A5_A5A5_A5A5; trap_cause = 4'hC; trap_val = 64'h5A5A_5A5A_5A5A_5A5A;
    last = (v.rst_cyc != 0) ? v.rst_cyc + v.tail : v.lat + v.tail;
    for (int c = 1; c <= last; c++) begin
      logic        e_busy, e_rv;
      logic [63:0] e_rpc;
      logic [1:0]  e_rnp;
      if (v.pulse && c == 3) trap_req = 1'b1;
      if (v.pulse && c == 4) trap_req = 1'b0;
      if (v.rst_cyc != 0 && c == v.rst_cyc) rst = 1'b1;
      if (v.rst_cyc != 0 && c == v.rst_cyc + 1) rst = 1'b0;
      @(negedge clk);
      tag = $sformatf("v%0d c%0d", idx, c);
      if (v.rst_cyc != 0) begin
        e_busy = (c <= v.rst_cyc);
        e_rv   = 1'b0;
        e_rpc  = (c <= v.rst_cyc) ? prev_pc : 64'h0;
        e_rnp  = (c <= v.rst_cyc) ? prev_np : 2'b00;
      end else begin
        e_busy = (c <= v.lat);
        e_rv   = (c == v.lat);
        e_rpc  = (c >= v.lat) ? v.e_pc : prev_pc;
        e_rnp  = (c >= v.lat) ? v.e_np : prev_np;
      end
      chk({tag, " busy"}, 64'(busy), 64'(e_busy));
      chk({tag, " redirect_valid"}, 64'(redirect_valid), 64'(e_rv));
      chk({tag, " redirect_pc"}, redirect_pc, e_rpc);
      chk({tag, " new_priv"}, 64'(new_priv), 64'(e_rnp));
      chk({tag, " csr_priv"}, 64'(csr_priv), e_busy ? 64'd1 : 64'd0);
      if (!e_busy) chk({tag, " idle csr_addr"}, 64'(csr_addr), 64'h0);
      if (csr_we) begin
        if (wq.size() == 0) begin
          n_vec++; n_bad++;
          $display("FAIL %s unexpected write: got addr %h data %h required none", tag, csr_addr, csr_wdata);
        end else begin
          w = wq.pop_front();
          chk({tag, " wr_cycle"}, 64'(c), 64'(w.cyc));
          chk({tag, " wr_addr"}, 64'(csr_addr), 64'(w.addr));
          chk({tag, " wr_data"}, csr_wdata, w.data);
        end
        model_wr(csr_addr, csr_wdata);
      end else begin
        chk({tag, " wdata_zero"}, csr_wdata, 64'h0);
      end
      @(posedge clk); #1;
    end
    chk($sformatf("v%0d writes_left", idx), 64'(wq.size()), 64'h0);
    wq.delete();
    if (v.rst_cyc != 0) begin
      prev_pc = 64'h0; prev_np = 2'b00;
    end else begin
      prev_pc = v.e_pc; prev_np = v.e_np;
    end
  endtask

  initial begin
    // trap sret priv pc cause val sst0 stvec sepc0 | e_sepc e_cause e_stval e_sst e_pc e_np lat rst_cyc tail pulse
    vt[0] = '{1, 0, 2'd0, 64'h8000_0103, 4'd2, 64'h142, 64'h2, 64'h8000_1001, 64'h0,
              64'h8000_0102, 64'd2, 64'h142, 64'h20, 64'h8000_1000, 2'd1, 7, 0, 2, 0};
    vt[1] = '{0, 1, 2'd1, 64'h5550, 4'd0, 64'h0, 64'h120, 64'h0, 64'h4001,
              64'h0, 64'h0, 64'h0, 64'h22, 64'h4000, 2'd1, 4, 0, 2, 0};
    vt[2] = '{0, 1, 2'd1, 64'h0, 4'd0, 64'h0, 64'h020, 64'h0, 64'h8000_0004,
              64'h0, 64'h0, 64'h0, 64'h22, 64'h8000_0004, 2'd0, 4, 0, 2, 0};
    vt[3] = '{0, 1, 2'd0, 64'h1235, 4'd7, 64'hDEAD, 64'h2, 64'h200, 64'h0,
              64'h1234, 64'd2, 64'h0, 64'h20, 64'h200, 2'd1, 7, 0, 2, 0};
    vt[4] = '{1, 1, 2'd1, 64'h2000, 4'd5, 64'h77, 64'h0, 64'hFFFF_FFFF_FFFF_FF03, 64'h0,
              64'h2000, 64'd5, 64'h77, 64'h100, 64'hFFFF_FFFF_FFFF_FF00, 2'd1, 7, 0, 2, 1};
    vt[5] = '{1, 0, 2'd1, 64'hFFFF_FFFF_FFFF_FFFF, 4'hF, 64'hFFFF_FFFF_FFFF_FFFF,
              64'hFFFF_FFFF_FFFF_FFFF, 64'h3, 64'h0,
              64'hFFFF_FFFF_FFFF_FFFE, 64'hF, 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFD,
              64'h0, 2'd1, 7, 0, 0, 0};
    vt[6] = '{0, 1, 2'd1, 64'h0, 4'd0, 64'h0, 64'hFFFF_FFFF_FFFF_FFFF, 64'h0, 64'h3,
              64'h0, 64'h0, 64'h0, 64'hFFFF_FFFF_FFFF_FEFF, 64'h2, 2'd1, 4, 0, 0, 0};
    vt[7] = '{1, 0, 2'd0, 64'h100, 4'd3, 64'h5, 64'h22, 64'h1000, 64'h0,
              64'h100, 64'd3, 64'h5, 64'h20, 64'h1000, 2'd1, 7, 0, 2, 0};
    vt[8] = '{1, 0, 2'd1, 64'h3000, 4'd1, 64'h9, 64'h2, 64'h4000, 64'h0,
              64'h3000, 64'd1, 64'h9, 64'h0, 64'h0, 2'd0, 7, 4, 3, 0};
    vt[9] = '{1, 0, 2'd1, 64'h3004, 4'd1, 64'h9, 64'h2, 64'h4000, 64'h0,
              64'h3004, 64'd1, 64'h9, 64'h120, 64'h4000, 2'd1, 7, 0, 2, 0};

    m_sstatus = '0; m_stvec = '0; m_sepc = '0; m_scause = '0; m_stval = '0;
    rst = 1'b1; trap_req = 1'b0; sret_req = 1'b0; priv_lvl = 2'b00;
    trap_pc = '0; trap_cause = '0; trap_val = '0;
    prev_pc = '0; prev_np = '0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("reset busy", 64'(busy), 64'h0);
    chk("reset csr_we", 64'(csr_we), 64'h0);
    chk("reset csr_addr", 64'(csr_addr), 64'h0);
    chk("reset csr_wdata", csr_wdata, 64'h0);
    chk("reset csr_priv", 64'(csr_priv), 64'h0);
    chk("reset redirect_valid", 64'(redirect_valid), 64'h0);
    chk("reset redirect_pc", redirect_pc, 64'h0);
    chk("reset new_priv", 64'(new_priv), 64'h0);
    @(posedge clk); #1;

    for (int i = 0; i < 10; i++) run_seq(i, vt[i]);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
